pll_phase_ctrl: RTL and testbench

PLL_PHASE_CTRL -- requirements
Module: pll_phase_ctrl

---
 rtl/pll_phase_ctrl.sv | 128 ++++++++++++
 tb/tb_pll_phase_ctrl.sv | 154 +++++++++++++++
 2 files changed

// File: rtl/pll_phase_ctrl.sv
// rtl/pll_phase_ctrl.sv - dynamic phase-step sequencer for PLL output clocks
module pll_phase_ctrl #(
  parameter int SETUP_CYC = 2,
  parameter int STEP_LOW  = 4,
  parameter int STEP_GAP  = 4,
  parameter int PHASE_MOD = 40
) (
  input  logic       clkin,
  input  logic       rst,
  input  logic       locked,
  input  logic       req_valid,
  output logic       req_ready,
  input  logic [1:0] req_sel,
  input  logic       req_dir,
  input  logic [7:0] req_steps,
  output logic       busy,
  output logic       done,
  output logic       err,
  output logic       phasesel0,
  output logic       phasesel1,
  output logic       phasedir,
  output logic       phasestep,
  output logic       phaseloadreg,
  output logic [5:0] pos_a,
  output logic [5:0] pos_b,
  output logic [5:0] pos_c,
  output logic [5:0] pos_d
);

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_SETUP = 3'd1;
  localparam logic [2:0] S_LOW   = 3'd2;
  localparam logic [2:0] S_GAP   = 3'd3;
  localparam logic [2:0] S_DONE  = 3'd4;

  localparam logic [7:0] SETUP_LAST = 8'(SETUP_CYC - 1);
  localparam logic [7:0] LOW_LAST   = 8'(STEP_LOW - 1);
  localparam logic [7:0] GAP_LAST   = 8'(STEP_GAP - 1);
  localparam logic [5:0] POS_MAX    = 6'(PHASE_MOD - 1);

  logic [2:0] state;
  logic [2:0] state_nxt;
  logic [7:0] cnt;
  logic [7:0] remaining;
  logic [1:0] sel_q;
  logic       dir_q;
  logic [5:0] pos [4];
  logic       accept;
  logic       in_run;
  logic       step_count;

  assign req_ready    = (state == S_IDLE) && locked;
  assign accept       = req_valid && req_ready;
  assign in_run       = (state == S_SETUP) || (state == S_LOW) || (state == S_GAP);
  // A step only counts when its low pulse ran to full length with lock held.
  assign step_count   = (state == S_LOW) && locked && (cnt == LOW_LAST);

  assign phasesel0    = sel_q[0];
  assign phasesel1    = sel_q[1];
  assign phasedir     = dir_q;
  assign phaseloadreg = 1'b1;
  assign pos_a        = pos[0];
  assign pos_b        = pos[1];
  assign pos_c        = pos[2];
  assign pos_d        = pos[3];

  // Next-state decode; loss of lock anywhere in the run aborts straight to DONE.
  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE: begin
        if (accept) state_nxt = S_SETUP;
      end
      S_SETUP: begin
        if (!locked) state_nxt = S_DONE;
        else if (cnt == SETUP_LAST) state_nxt = (remaining != 8'd0) ? S_LOW : S_DONE;
      end
      S_LOW: begin
        if (!locked) state_nxt = S_DONE;
        else if (cnt == LOW_LAST) state_nxt = S_GAP;
      end
      S_GAP: begin
        if (!locked) state_nxt = S_DONE;
        else if (cnt == GAP_LAST) state_nxt = (remaining != 8'd0) ? S_LOW : S_DONE;
      end
      S_DONE:  state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  // State, dwell counter, registered PLL-facing outputs and position tracking.
  always_ff @(posedge clkin) begin
    if (rst) begin
      state     <= S_IDLE;
      cnt       <= 8'd0;
      remaining <= 8'd0;
      sel_q     <= 2'd0;
      dir_q     <= 1'b1;
      phasestep <= 1'b1;
      busy      <= 1'b0;
      done      <= 1'b0;
      err       <= 1'b0;
      for (int i = 0; i < 4; i++) pos[i] <= 6'd0;
    end else begin
      state     <= state_nxt;
      cnt       <= (state_nxt != state) ? 8'd0 : cnt + 8'd1;
      phasestep <= (state_nxt != S_LOW);
      busy      <= (state_nxt != S_IDLE);
      done      <= (state_nxt == S_DONE);

      if (accept) begin
        sel_q     <= req_sel;
        dir_q     <= req_dir;
        remaining <= req_steps;
        err       <= 1'b0;
      end

      if (in_run && !locked) err <= 1'b1;

      if (step_count) begin
        remaining <= remaining - 8'd1;
        if (!dir_q) pos[sel_q] <= (pos[sel_q] == POS_MAX) ? 6'd0 : pos[sel_q] + 6'd1;
        else        pos[sel_q] <= (pos[sel_q] == 6'd0) ? POS_MAX : pos[sel_q] - 6'd1;
      end
    end
  end

endmodule

// File: tb/tb_pll_phase_ctrl.sv
// tb/tb_pll_phase_ctrl.sv - randomized bench for pll_phase_ctrl against a schedule model
module tb_pll_phase_ctrl;

  logic       clkin = 1'b0;
  logic       rst = 1'b1;
  logic       locked = 1'b1;
  logic       req_valid = 1'b0;
  logic       req_ready;
  logic [1:0] req_sel = 2'd0;
  logic       req_dir = 1'b0;
  logic [7:0] req_steps = 8'd0;
  logic       busy, done, err;
  logic       phasesel0, phasesel1, phasedir, phasestep, phaseloadreg;
  logic [5:0] pos_a, pos_b, pos_c, pos_d;

  pll_phase_ctrl dut (
    .clkin(clkin), .rst(rst), .locked(locked),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_sel(req_sel), .req_dir(req_dir), .req_steps(req_steps),
    .busy(busy), .done(done), .err(err),
    .phasesel0(phasesel0), .phasesel1(phasesel1), .phasedir(phasedir),
    .phasestep(phasestep), .phaseloadreg(phaseloadreg),
    .pos_a(pos_a), .pos_b(pos_b), .pos_c(pos_c), .pos_d(pos_d)
  );

  always #5 clkin = ~clkin;

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  // Model: one request described by accept cycle n, step count s, abort cycle l.
  bit       act = 1'b0;
  int       n = 0;
  int       s = 0;
  int       l = -1;
  bit [1:0] msel = 2'd0;
  bit       mdir = 1'b1;
  int       pos_m [4] = '{0, 0, 0, 0};

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s cycle=%0d got=%0d want=%0d", tag, cyc, obs, exp);
    end
  endtask

  function automatic int end_cyc();
    return (l >= 0) ? l + 1 : n + 3 + s * 8;
  endfunction

  function automatic bit busy_exp(input int c);
    return act && c >= n + 1 && c <= end_cyc();
  endfunction

  function automatic bit low_exp(input int c);
    if (!act || c >= end_cyc()) return 1'b0;
    for (int k = 0; k < s; k++)
      if (c >= n + 3 + 8 * k && c <= n + 6 + 8 * k) return 1'b1;
    return 1'b0;
  endfunction

  function automatic int steps_done(input int c);
    int d = 0;
    for (int k = 0; k < s; k++)
      if (n + 7 + 8 * k <= c && (l < 0 || n + 6 + 8 * k < l)) d++;
    return d;
  endfunction

  function automatic int cur_pos(input int i, input int c);
    int d;
    if (!act || i != int'(msel)) return pos_m[i];
    d = steps_done(c) % 40;
    return mdir ? (pos_m[i] - d + 40) % 40 : (pos_m[i] + d) % 40;
  endfunction

  task automatic step_cycle(input bit r, input bit lk, input bit v, input bit [1:0] sl,
                            input bit d, input int st);
    @(posedge clkin);
    cyc++;
    #1;
    chk("busy", busy, busy_exp(cyc));
    chk("done", done, act && cyc == end_cyc());
    chk("phasestep", phasestep, !low_exp(cyc));
    chk("err", err, act && l >= 0 && cyc > l);
    chk("phasesel", {phasesel1, phasesel0}, act ? msel : 2'd0);
    chk("phasedir", phasedir, act ? mdir : 1'b1);
    chk("phaseloadreg", phaseloadreg, 1'b1);
    chk("pos_a", pos_a, cur_pos(0, cyc));
    chk("pos_b", pos_b, cur_pos(1, cyc));
    chk("pos_c", pos_c, cur_pos(2, cyc));
    chk("pos_d", pos_d, cur_pos(3, cyc));
    rst = r; locked = lk; req_valid = v; req_sel = sl; req_dir = d; req_steps = 8'(st);
    #1;
    chk("req_ready", req_ready, lk && !busy_exp(cyc));
    if (r) begin
      act = 1'b0;
      for (int i = 0; i < 4; i++) pos_m[i] = 0;
    end else if (act && l < 0 && !lk && cyc >= n + 1 && cyc <= n + 2 + s * 8) begin
      l = cyc;
    end else if (v && lk && !busy_exp(cyc)) begin
      if (act) pos_m[msel] = cur_pos(int'(msel), cyc);
      act = 1'b1; n = cyc; s = st; l = -1; msel = sl; mdir = d;
    end
  endtask

  task automatic idle(input int k);
    for (int i = 0; i < k; i++) step_cycle(1'b0, 1'b1, 1'b0, 2'd0, 1'b0, 0);
  endtask

  task automatic req(input bit [1:0] sl, input bit d, input int st);
    step_cycle(1'b0, 1'b1, 1'b1, sl, d, st);
  endtask

  initial begin
    for (int i = 0; i < 3; i++) step_cycle(1'b1, 1'b1, 1'b0, 2'd0, 1'b0, 0);

    req(2'd1, 1'b0, 3);  idle(35);
    req(2'd3, 1'b1, 1);  idle(15);
    req(2'd3, 1'b0, 41); idle(340);
    req(2'd0, 1'b0, 0);  idle(10);

    req(2'd2, 1'b0, 5);  idle(11);
    for (int i = 0; i < 3; i++) step_cycle(1'b0, 1'b0, 1'b1, 2'd1, 1'b1, 7);
    idle(10);

    req(2'd1, 1'b1, 4);  idle(4);
    step_cycle(1'b1, 1'b1, 1'b1, 2'd2, 1'b0, 2);
    idle(3);

    req(2'd0, 1'b0, 2);
    for (int i = 0; i < 25; i++) step_cycle(1'b0, 1'b1, 1'b1, 2'd3, 1'b1, 1);
    idle(20);

    for (int i = 0; i < 4000; i++) begin
      bit r, lk, v, d;
      bit [1:0] sl;
      int st;
      r  = ($urandom_range(0, 399) == 0);
      lk = ($urandom_range(0, 79) != 0);
      v  = ($urandom_range(0, 3) == 0);
      sl = 2'($urandom_range(0, 3));
      d  = 1'($urandom_range(0, 1));
      st = ($urandom_range(0, 9) == 0) ? $urandom_range(0, 50) : $urandom_range(0, 4);
      step_cycle(r, lk, v, sl, d, st);
    end
    idle(5);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
